seq_alu: RTL and testbench

- Parametrised, registered, multi-cycle successor to the combinational 16-bit datapath ALU.
- Sits in the execute stage. Accepts an op and two signed operands on a start pulse, returns the result on a done pulse.
- Add, subtract and logic ops complete in 1 cycle. Multiply (shift-add) and divide (restoring) are iterative, 1 bit per cycle.
- Adds correct signed overflow, divide-by-zero handling and a busy handshake, none of which the combinational version has.

---
 rtl/seq_alu.sv | 273 +++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered, multi-cycle execute-stage ALU.
//
// Ops (ctrl): 1 ADD, 2 SUB, 4 MUL, 8 DIV, C AND, E OR, F ADD without flag update.
// ADD/SUB/logic ops finish in one cycle. MUL is shift-add and DIV is restoring
// division, each taking one bit per cycle over WIDTH cycles.
//
// Handshake: start is sampled only in IDLE. The op is accepted on a clock edge
// where state is IDLE and start=1. Operands and opcode are latched on that edge
// and ignored afterwards. busy is high while an iterative op runs. done is a
// one-cycle pulse, and out/r0/overflow_flag/err are valid from the done cycle
// until the next done. A start that arrives while busy or in the done cycle is
// dropped, not queued.
//
// Ports:
//   clk, reset (async, active-low)
//   start, ctrl[3:0], in1/in2[WIDTH-1:0] (signed)   - request
//   busy, done                                      - status
//   out, r0 [WIDTH-1:0], overflow_flag, err         - results
//   dbg_state[1:0]                                  - FSM state (0 IDLE, 1 ITER, 2 FIN)
//   zero_flag, neg_flag                             - only with SEQ_ALU_STATUS_EN
//
// Optional feature macro: SEQ_ALU_STATUS_EN adds the registered zero/negative
// flags of out.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] r0,
  output logic             overflow_flag,
  output logic [1:0]       dbg_state,
  output logic             err
`ifdef SEQ_ALU_STATUS_EN
  ,
  output logic             zero_flag,
  output logic             neg_flag
`endif
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hE;
  localparam logic [3:0] OP_ADDF = 4'hF;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIN = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;     // partial product high half / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;     // multiplier bits / dividend bits becoming quotient
  logic               qneg_q, qneg_d; // product or quotient is negative
  logic               rneg_q, rneg_d; // remainder is negative (sign of in1)
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   r0_q, r0_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (ctrl == OP_MUL || (ctrl == OP_DIV && in2 != '0)) state_d = S_ITER;
        else                                                 state_d = S_FIN;
      end
      S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state_q == S_ITER);
    done      = (state_q == S_FIN);
    dbg_state = state_q;
  end

  // ---------------- single-cycle datapath ----------------
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, sum, diff;
  logic             add_ovf, sub_ovf;
  always_comb begin
    sa      = in1[WIDTH-1];
    sb      = in2[WIDTH-1];
    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
    mag_a   = sa ? -in1 : in1;
    mag_b   = sb ? -in2 : in2;
    sum     = in1 + in2;
    diff    = in1 - in2;
    add_ovf = (sa == sb) && (sum[WIDTH-1] != sa);
    sub_ovf = (sa != sb) && (diff[WIDTH-1] != sa);
  end

  // ---------------- iterative step ----------------
  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0]   fin_out, fin_r0, quo_s, rem_s;
  logic               fin_ovf;
  always_comb begin
    // MUL: conditional add then shift the {carry,hi,lo} pair right by one.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    // DIV: shift next dividend bit into the remainder, subtract divisor if it fits.
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, mag_q});
    rem_sub = rem_sh - {1'b0, mag_q};
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], rem_ge};
    end
    // Sign correction of the final step's result.
    prod_mag = {step_hi, step_lo};
    prod_s   = qneg_q ? -prod_mag : prod_mag;
    quo_s    = qneg_q ? -step_lo : step_lo;
    rem_s    = rneg_q ? -step_hi : step_hi;
    if (op_q == OP_MUL) begin
      fin_out = prod_s[WIDTH-1:0];
      fin_r0  = prod_s[2*WIDTH-1:WIDTH];
      fin_ovf = (fin_r0 != {WIDTH{fin_out[WIDTH-1]}});
    end else begin
      fin_out = quo_s;
      fin_r0  = rem_s;
      // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
      fin_ovf = step_lo[WIDTH-1] & ~qneg_q;
    end
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    op_d   = op_q;
    cnt_d  = cnt_q;
    mag_d  = mag_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    out_d  = out_q;
    r0_d   = r0_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    if (state_q == S_IDLE && start) begin
      op_d = ctrl;
      case (ctrl)
        OP_ADD:  begin out_d = sum;  r0_d = '0; ovf_d = add_ovf; err_d = 1'b0; end
        OP_ADDF: begin out_d = sum;  r0_d = '0;                  err_d = 1'b0; end
        OP_SUB:  begin out_d = diff; r0_d = '0; ovf_d = sub_ovf; err_d = 1'b0; end
        OP_AND:  begin out_d = in1 & in2; r0_d = '0; ovf_d = 1'b0; err_d = 1'b0; end
        OP_OR:   begin out_d = in1 | in2; r0_d = '0; ovf_d = 1'b0; err_d = 1'b0; end
        OP_MUL: begin
          mag_d  = mag_a;
          hi_d   = '0;
          lo_d   = mag_b;
          qneg_d = sa ^ sb;
          cnt_d  = CNT_W'(WIDTH);
        end
        OP_DIV: begin
          if (in2 == '0) begin
            out_d = '1; r0_d = in1; ovf_d = 1'b0; err_d = 1'b1;
          end else begin
            mag_d  = mag_b;
            hi_d   = '0;
            lo_d   = mag_a;
            qneg_d = sa ^ sb;
            rneg_d = sa;
            cnt_d  = CNT_W'(WIDTH);
          end
        end
        default: err_d = 1'b1; // illegal opcode: results keep their values
      endcase
    end else if (state_q == S_ITER) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        out_d = fin_out;
        r0_d  = fin_r0;
        ovf_d = fin_ovf;
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      cnt_q  <= '0;
      mag_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      out_q  <= '0;
      r0_q   <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      mag_q  <= mag_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      out_q  <= out_d;
      r0_q   <= r0_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  assign out           = out_q;
  assign r0            = r0_q;
  assign overflow_flag = ovf_q;
  assign err           = err_q;

`ifdef SEQ_ALU_STATUS_EN
  logic zero_q, zero_d, negf_q, negf_d;
  logic legal_start;
  always_comb begin
    // Flags follow out on every legal completion; illegal opcodes leave them alone.
    legal_start = 1'b0;
    case (ctrl)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_ADDF: legal_start = 1'b1;
      default: legal_start = 1'b0;
    endcase
    zero_d = zero_q;
    negf_d = negf_q;
    if ((state_q == S_IDLE && start && legal_start && state_d == S_FIN) ||
        (state_q == S_ITER && cnt_q == CNT_W'(1))) begin
      zero_d = (out_d == '0);
      negf_d = out_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q <= 1'b0;
      negf_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      negf_q <= negf_d;
    end
  end

  assign zero_flag = zero_q;
  assign neg_flag  = negf_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=16): directed cases followed by randomized ops,
// all checked against a plain-arithmetic reference model.
module tb_seq_alu;
  localparam int W     = 16;
  localparam int EXP_W = 2 * W + 2;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   ctrl;
  logic [W-1:0] in1, in2;
  logic         busy, done, overflow_flag, err;
  logic [W-1:0] out, r0;
  logic [1:0]   dbg_state;
`ifdef SEQ_ALU_STATUS_EN
  logic         zero_flag, neg_flag;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ctrl(ctrl), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .r0(r0), .overflow_flag(overflow_flag),
    .dbg_state(dbg_state), .err(err)
`ifdef SEQ_ALU_STATUS_EN
    , .zero_flag(zero_flag), .neg_flag(neg_flag)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model state: what the ALU should be holding.
  logic [W-1:0] m_out = '0, m_r0 = '0;
  logic         m_ovf = 1'b0, m_err = 1'b0, m_zero = 1'b0, m_neg = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic fits(input longint v);
    return (v >= MINV) && (v <= MAXV);
  endfunction

  // Updates the model with the outcome of one op and returns its latency.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    longint x, y, res, q, r;
    logic   legal;
    x = longint'($signed(a));
    y = longint'($signed(b));
    lat = 1;
    legal = 1'b1;
    case (op)
      4'h1, 4'hF: begin
        res = x + y; m_out = res[W-1:0]; m_r0 = '0; m_err = 1'b0;
        if (op == 4'h1) m_ovf = !fits(res);
      end
      4'h2: begin res = x - y; m_out = res[W-1:0]; m_r0 = '0; m_ovf = !fits(res); m_err = 1'b0; end
      4'h4: begin
        res = x * y; m_out = res[W-1:0]; m_r0 = res[2*W-1:W]; m_ovf = !fits(res);
        m_err = 1'b0; lat = W + 1;
      end
      4'h8: begin
        if (y == 0) begin
          m_out = '1; m_r0 = a; m_ovf = 1'b0; m_err = 1'b1;
        end else begin
          q = x / y; r = x % y;
          m_out = q[W-1:0]; m_r0 = r[W-1:0]; m_ovf = !fits(q); m_err = 1'b0; lat = W + 1;
        end
      end
      4'hC: begin m_out = a & b; m_r0 = '0; m_ovf = 1'b0; m_err = 1'b0; end
      4'hE: begin m_out = a | b; m_r0 = '0; m_ovf = 1'b0; m_err = 1'b0; end
      default: begin m_err = 1'b1; legal = 1'b0; end
    endcase
    if (legal) begin
      m_zero = (m_out == '0);
      m_neg  = m_out[W-1];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"},  32'(out), 32'h0);
    check({tag, "_r0"},   32'(r0), 32'h0);
    check({tag, "_ovf"},  32'(overflow_flag), 32'h0);
    check({tag, "_err"},  32'(err), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // ---------------- driver ----------------
  // intr_at > 0: pulse an ADD start that many cycles after the start cycle.
  // rst_at  > 0: assert reset that many cycles after the start cycle (op aborted).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intr_at, input int rst_at);
    int exp_lat, lat, busy_cnt;
    bit seen;
    logic [EXP_W-1:0] e;
    model(op, a, b, exp_lat);
    exp_q.push_back({m_err, m_ovf, m_r0, m_out});
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'h0);
    start = 1'b1; ctrl = op; in1 = a; in2 = b;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat <= 3 * W) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Scramble inputs: they must no longer matter.
        start = 1'b0; ctrl = 4'($urandom); in1 = W'($urandom); in2 = W'($urandom);
      end
      if (intr_at > 0 && lat == intr_at) begin
        start = 1'b1; ctrl = 4'h1;
      end else if (intr_at > 0 && lat == intr_at + 1) begin
        start = 1'b0;
      end
      if (rst_at > 0 && lat == rst_at) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) begin
          @(negedge clk);
          check("no_done_in_reset", 32'(done), 32'h0);
        end
        reset = 1'b1;
        void'(exp_q.pop_back());
        m_out = '0; m_r0 = '0; m_ovf = 1'b0; m_err = 1'b0; m_zero = 1'b0; m_neg = 1'b0;
        return;
      end
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
    e = exp_q.pop_front();
    check("out", 32'(out), 32'(e[W-1:0]));
    check("r0", 32'(r0), 32'(e[2*W-1:W]));
    check("ovf", 32'(overflow_flag), 32'(e[2*W]));
    check("err", 32'(err), 32'(e[2*W+1]));
`ifdef SEQ_ALU_STATUS_EN
    check("zero_flag", 32'(zero_flag), 32'(m_zero));
    check("neg_flag", 32'(neg_flag), 32'(m_neg));
`endif
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return W'(MINV);
      4: return W'(MAXV);
      5: return W'($urandom_range(0, 20)) - W'(10);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [3:0] op_tab [8];

  initial begin
    op_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF, 4'h3};
    reset = 1'b0; start = 1'b0; ctrl = '0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Signed overflow on ADD, then flag-preserving ADD.
    run_op(4'h1, 16'h7FFF, 16'h0001, 0, 0);
    check("tp_add_out", 32'(out), 32'h8000);
    check("tp_add_ovf", 32'(overflow_flag), 32'h1);
    run_op(4'hF, 16'h7FFF, 16'h0001, 0, 0);
    check("tp_addf_ovf", 32'(overflow_flag), 32'h1);

    // Multiply: negative result, then a product overflowing the low half.
    run_op(4'h4, 16'hFFFD, 16'h0005, 0, 0);
    check("tp_mul_r0", 32'(r0), 32'hFFFF);
    check("tp_mul_out", 32'(out), 32'hFFF1);
    run_op(4'h4, 16'd300, 16'd300, 0, 0);
    check("tp_mul2_out", 32'(out), 32'h5F90);
    check("tp_mul2_ovf", 32'(overflow_flag), 32'h1);

    // Divide: truncation, MIN / -1, divide by zero, then recovery.
    run_op(4'h8, 16'hFFF9, 16'h0002, 0, 0);
    check("tp_div_out", 32'(out), 32'hFFFD);
    check("tp_div_r0", 32'(r0), 32'hFFFF);
    run_op(4'h8, 16'h8000, 16'hFFFF, 0, 0);
    check("tp_divmin_out", 32'(out), 32'h8000);
    run_op(4'h8, 16'd1234, 16'h0000, 0, 0);
    check("tp_div0_r0", 32'(r0), 32'h04D2);
    run_op(4'hC, 16'h0F0F, 16'h00FF, 0, 0);
    check("tp_and_out", 32'(out), 32'h000F);

    // Illegal opcode, then SUB to zero.
    run_op(4'h3, 16'h1234, 16'h5678, 0, 0);
    run_op(4'h2, 16'd5, 16'd5, 0, 0);

    // Start while busy is dropped; reset mid-MUL aborts; next op runs normally.
    run_op(4'h8, 16'd100, 16'd7, 5, 0);
    run_op(4'h4, 16'd123, 16'hFF00, 0, 8);
    run_op(4'h1, 16'd20, 16'hFFF6, 0, 0);

    // Random ops, including back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      run_op(op_tab[$urandom_range(0, 7)], pick_operand(), pick_operand(), 0, 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
